tl_line_master: RTL and testbench

TileLink-UL initiator that moves whole 64-byte lines between a simple 512-bit request/response port and a 64-bit TileLink A/D link. It is the counterpart of the DDR3 TileLink responder. Clients such as the framebuffer scan-out, DMA copy and cache refill logic use it to issue 64-byte Get and PutFull bursts into memory. Only one transaction is outstanding at a time, under a single fixed source ID.

---
 rtl/tl_line_master.sv | 190 +++++++++++++++++++
 tb/tb_tl_line_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_line_master.sv
// TileLink-UL initiator moving whole 64-byte lines between a 512-bit request/response
// port and a 64-bit A/D link; one transaction outstanding under a fixed source ID.
module tl_line_master #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int SOURCE_WIDTH  = 4,
    parameter int SOURCE_ID     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [511:0]             req_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic                     rsp_error,
    output logic [511:0]             rsp_data,
    output logic                     tl_a_valid,
    input  logic                     tl_a_ready,
    output logic [2:0]               tl_a_opcode,
    output logic [2:0]               tl_a_param,
    output logic [SOURCE_WIDTH-1:0]  tl_a_source,
    output logic [ADDRESS_WIDTH-1:0] tl_a_address,
    output logic [2:0]               tl_a_size,
    output logic [7:0]               tl_a_mask,
    output logic [63:0]              tl_a_data,
    output logic                     tl_a_corrupt,
    input  logic                     tl_d_valid,
    input  logic [2:0]               tl_d_opcode,
    input  logic [2:0]               tl_d_param,
    input  logic [SOURCE_WIDTH-1:0]  tl_d_source,
    input  logic [2:0]               tl_d_size,
    input  logic                     tl_d_denied,
    input  logic [63:0]              tl_d_data,
    input  logic                     tl_d_corrupt,
    output logic                     tl_d_ready
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_A_SEND = 2'd1;
    localparam logic [1:0] S_D_WAIT = 2'd2;
    localparam logic [1:0] S_RSP    = 2'd3;

    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;
    localparam logic [SOURCE_WIDTH-1:0] SRC = SOURCE_WIDTH'(SOURCE_ID);

    logic [1:0]               state_q, state_d;
    logic                     write_q, write_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [511:0]             wline_q, wline_d;
    logic [511:0]             rdata_q, rdata_d;
    logic [2:0]               a_beat_q, a_beat_d;
    logic [2:0]               d_beat_q, d_beat_d;
    logic                     err_q, err_d;
    logic                     ack_q, ack_d;
    logic                     req_ready_q, tl_a_valid_q, rsp_valid_q;
    logic                     req_fire, a_fire, d_fire, d_bad;
    logic                     unused_ok;

    assign req_fire = req_valid & req_ready_q;
    assign a_fire   = tl_a_valid_q & tl_a_ready;
    assign d_fire   = tl_d_valid & tl_d_ready;
    assign d_bad    = tl_d_denied | tl_d_corrupt | (tl_d_source != SRC) |
                      (tl_d_opcode != (write_q ? OP_ACK : OP_ACK_DATA));

    assign tl_d_ready   = (state_q == S_A_SEND) || (state_q == S_D_WAIT);
    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_write    = write_q;
    assign rsp_error    = err_q;
    assign rsp_data     = rdata_q;
    assign tl_a_valid   = tl_a_valid_q;
    assign tl_a_opcode  = write_q ? OP_PUT_FULL : OP_GET;
    assign tl_a_param   = 3'd0;
    assign tl_a_source  = SRC;
    assign tl_a_address = addr_q;
    assign tl_a_size    = 3'd6;
    assign tl_a_mask    = 8'hFF;
    assign tl_a_corrupt = 1'b0;
    // The write line shifts down one word per accepted A beat, so beat a_beat sits in [63:0].
    assign tl_a_data    = wline_q[63:0];
    assign unused_ok    = ^{tl_d_param, tl_d_size, req_address[5:0]};

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wline_d  = wline_q;
        rdata_d  = rdata_q;
        a_beat_d = a_beat_q;
        d_beat_d = d_beat_q;
        err_d    = err_q;
        ack_d    = ack_q;
        if (d_fire) begin
            err_d = err_q | d_bad;
        end
        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    state_d  = S_A_SEND;
                    write_d  = req_write;
                    addr_d   = {req_address[ADDRESS_WIDTH-1:6], 6'b0};
                    wline_d  = req_write ? req_data : '0;
                    a_beat_d = 3'd0;
                    d_beat_d = 3'd0;
                    err_d    = 1'b0;
                    ack_d    = 1'b0;
                end
            end
            S_A_SEND: begin
                // An ack can overtake the tail of a PutFull burst; remember it.
                if (d_fire) begin
                    if (write_q) begin
                        ack_d = 1'b1;
                    end else begin
                        rdata_d[{d_beat_q, 6'b0} +: 64] = tl_d_data;
                        d_beat_d = d_beat_q + 3'd1;
                    end
                end
                if (a_fire) begin
                    if (!write_q) begin
                        state_d = S_D_WAIT;
                    end else begin
                        wline_d  = {64'd0, wline_q[511:64]};
                        a_beat_d = a_beat_q + 3'd1;
                        if (a_beat_q == 3'd7) begin
                            state_d = (ack_q || d_fire) ? S_RSP : S_D_WAIT;
                        end
                    end
                end
            end
            S_D_WAIT: begin
                if (d_fire) begin
                    if (write_q) begin
                        state_d = S_RSP;
                    end else begin
                        rdata_d[{d_beat_q, 6'b0} +: 64] = tl_d_data;
                        d_beat_d = d_beat_q + 3'd1;
                        if (d_beat_q == 3'd7) begin
                            state_d = S_RSP;
                        end
                    end
                end
            end
            S_RSP: begin
                if (rsp_ready && rsp_valid_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wline_q      <= '0;
            rdata_q      <= '0;
            a_beat_q     <= 3'd0;
            d_beat_q     <= 3'd0;
            err_q        <= 1'b0;
            ack_q        <= 1'b0;
            req_ready_q  <= 1'b0;
            tl_a_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wline_q      <= wline_d;
            rdata_q      <= rdata_d;
            a_beat_q     <= a_beat_d;
            d_beat_q     <= d_beat_d;
            err_q        <= err_d;
            ack_q        <= ack_d;
            // Handshake outputs are registered copies of the next-state decode.
            req_ready_q  <= (state_d == S_IDLE);
            tl_a_valid_q <= (state_d == S_A_SEND);
            rsp_valid_q  <= (state_d == S_RSP);
        end
    end

endmodule

// File: tb/tb_tl_line_master.sv
// Bench for tl_line_master: acts as client and TileLink responder, checking each line
// transfer against a transaction-level model of the expected beats, latency and response.
module tb_tl_line_master;

    localparam int AW  = 32;
    localparam int SW  = 4;
    localparam int SID = 0;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_address;
    logic [511:0]  req_data;
    logic          rsp_valid, rsp_ready, rsp_write, rsp_error;
    logic [511:0]  rsp_data;
    logic          tl_a_valid, tl_a_ready;
    logic [2:0]    tl_a_opcode, tl_a_param, tl_a_size;
    logic [SW-1:0] tl_a_source;
    logic [AW-1:0] tl_a_address;
    logic [7:0]    tl_a_mask;
    logic [63:0]   tl_a_data;
    logic          tl_a_corrupt;
    logic          tl_d_valid, tl_d_ready, tl_d_denied, tl_d_corrupt;
    logic [2:0]    tl_d_opcode, tl_d_param, tl_d_size;
    logic [SW-1:0] tl_d_source;
    logic [63:0]   tl_d_data;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [511:0] exp_line;

    always #5 clk = ~clk;

    tl_line_master #(.ADDRESS_WIDTH(AW), .SOURCE_WIDTH(SW), .SOURCE_ID(SID)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_error(rsp_error), .rsp_data(rsp_data),
        .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
        .tl_a_param(tl_a_param), .tl_a_source(tl_a_source), .tl_a_address(tl_a_address),
        .tl_a_size(tl_a_size), .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data),
        .tl_a_corrupt(tl_a_corrupt),
        .tl_d_valid(tl_d_valid), .tl_d_opcode(tl_d_opcode), .tl_d_param(tl_d_param),
        .tl_d_source(tl_d_source), .tl_d_size(tl_d_size), .tl_d_denied(tl_d_denied),
        .tl_d_data(tl_d_data), .tl_d_corrupt(tl_d_corrupt), .tl_d_ready(tl_d_ready)
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_a_valid"}, tl_a_valid, 0);
        check_eq({tag, "_d_ready"}, tl_d_ready, 0);
        check_eq({tag, "_rsp_error"}, rsp_error, 0);
        check_eq({tag, "_rsp_write"}, rsp_write, 0);
        check_eq({tag, "_rsp_data"}, rsp_data, 0);
        check_eq({tag, "_a_data"}, tl_a_data, 0);
    endtask

    // mode: 0 = A ready always, 1 = A ready toggles 1-0-1, 2 = random A ready and D gaps.
    // ack_after: number of A beats accepted before the responder offers the write ack.
    // err_kind: 0 none, 1 denied on err_beat, 2 corrupt on err_beat, 3 wrong source on
    // every beat, 4 wrong opcode on err_beat. abort_d >= 0 resets after that many D beats.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [511:0] line,
                          input int mode, input int ack_after, input int err_beat,
                          input int err_kind, input int rsp_hold, input int abort_d,
                          output int lat);
        int  a_cnt, d_cnt, a_prev, req_cyc, last_a, last_d, n_a;
        bit  acked, d_pend, tog, bad;
        lat    = -1;
        a_cnt  = 0;
        d_cnt  = 0;
        acked  = 0;
        d_pend = 0;
        tog    = 1;
        last_a = -1;
        last_d = -1;
        n_a    = wr ? 8 : 1;

        check_eq("req_ready_idle", req_ready, 1);
        req_valid   = 1;
        req_write   = wr;
        req_address = addr;
        req_data    = wr ? line : rand_line();
        req_cyc     = cyc;
        step();
        req_valid   = 0;
        req_data    = rand_line();
        req_address = $urandom;
        check_eq("a_valid_lat", tl_a_valid, 1);
        check_eq("a_address", tl_a_address, {addr[31:6], 6'b0});
        check_eq("a_opcode", tl_a_opcode, wr ? 3'd0 : 3'd4);
        check_eq("a_size", tl_a_size, 3'd6);
        check_eq("a_mask", tl_a_mask, 8'hFF);
        check_eq("a_source", tl_a_source, SID);

        for (int n = 0; n < 300 && !rsp_valid; n++) begin
            a_prev = a_cnt;
            if (abort_d >= 0 && !wr && d_cnt == abort_d) begin
                tl_d_valid = 0;
                tl_a_ready = 0;
                reset      = 1;
                step();
                check_reset_outputs("abort");
                exp_line = '0;
                reset    = 0;
                step();
                check_eq("abort_req_ready", req_ready, 1);
                return;
            end
            tl_a_ready = 0;
            if (tl_a_valid) begin
                if (a_cnt < n_a) begin
                    check_eq("a_data", tl_a_data, wr ? line[a_cnt*64 +: 64] : 64'd0);
                    check_eq("a_addr_hold", tl_a_address, {addr[31:6], 6'b0});
                end else begin
                    check_eq("a_extra_beat", a_cnt, n_a - 1);
                end
                case (mode)
                    0:       tl_a_ready = 1;
                    1:       begin tl_a_ready = tog; tog = ~tog; end
                    default: tl_a_ready = 1'($urandom_range(0, 1));
                endcase
                if (tl_a_ready) begin
                    a_cnt++;
                    if (a_cnt == n_a) last_a = cyc;
                end
            end
            tl_d_valid   = 0;
            tl_d_denied  = 0;
            tl_d_corrupt = 0;
            tl_d_source  = SW'(SID);
            tl_d_opcode  = wr ? 3'd0 : 3'd1;
            tl_d_data    = {$urandom, $urandom};
            if ((wr && !acked && a_prev >= ack_after) || (!wr && a_prev >= 1 && d_cnt < 8)) begin
                if (!d_pend) d_pend = (mode != 2) || ($urandom_range(0, 3) != 0);
                if (d_pend) begin
                    tl_d_valid = 1;
                    if (!wr) tl_d_data = line[d_cnt*64 +: 64];
                    bad = (d_cnt == err_beat);
                    if (err_kind == 1 && bad) tl_d_denied = 1;
                    if (err_kind == 2 && bad) tl_d_corrupt = 1;
                    if (err_kind == 3) tl_d_source = SW'(SID + 1);
                    if (err_kind == 4 && bad) tl_d_opcode = wr ? 3'd1 : 3'd0;
                    if (tl_d_ready) begin
                        d_pend = 0;
                        if (wr) begin
                            acked  = 1;
                            last_d = cyc;
                        end else begin
                            d_cnt++;
                            if (d_cnt == 8) last_d = cyc;
                        end
                    end
                end
            end
            step();
        end
        tl_a_ready = 0;
        tl_d_valid = 0;
        if (!rsp_valid) begin
            check_eq("rsp_timeout", rsp_valid, 1);
            return;
        end
        check_eq("a_beats", a_cnt, n_a);
        check_eq("d_beats", wr ? 32'(acked) : 32'(d_cnt), wr ? 1 : 8);
        check_eq("rsp_cycle", cyc, ((last_a > last_d) ? last_a : last_d) + 1);
        lat = cyc - req_cyc;
        if (!wr) exp_line = line;
        check_eq("rsp_write", rsp_write, wr);
        check_eq("rsp_error", rsp_error, err_kind != 0);
        check_eq("rsp_data", rsp_data, exp_line);
        check_eq("rsp_req_ready", req_ready, 0);
        check_eq("rsp_a_valid", tl_a_valid, 0);
        check_eq("rsp_d_ready", tl_d_ready, 0);
        for (int h = 0; h < rsp_hold; h++) begin
            rsp_ready = 0;
            step();
            check_eq("hold_rsp_valid", rsp_valid, 1);
            check_eq("hold_rsp_data", rsp_data, exp_line);
            check_eq("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        check_eq("post_rsp_valid", rsp_valid, 0);
        check_eq("post_req_ready", req_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [511:0] l;
        int           lat;
        bit           wr;
        int           ek;
        reset = 1; req_valid = 0; req_write = 0; req_address = '0; req_data = '0;
        rsp_ready = 0; tl_a_ready = 0; tl_d_valid = 0; tl_d_opcode = 0; tl_d_param = 0;
        tl_d_source = 0; tl_d_size = 3'd6; tl_d_denied = 0; tl_d_data = 0; tl_d_corrupt = 0;
        exp_line = '0;
        step();
        step();
        check_reset_outputs("reset");
        reset = 0;
        step();
        check_eq("req_ready_after_reset", req_ready, 1);

        for (int k = 0; k < 8; k++) l[k*64 +: 64] = 64'(8'h11 * (k + 1));
        do_txn(0, 32'h1000_0047, l, 0, 0, 0, 0, 0, -1, lat);
        check_eq("get_latency", lat, 10);
        check_eq("get_word0", rsp_data[63:0], 64'h11);
        check_eq("get_word7", rsp_data[511:448], 64'h88);

        for (int k = 0; k < 8; k++) l[k*64 +: 64] = 64'(8'hA0 + k);
        do_txn(1, 32'h2000_0100, l, 1, 8, 0, 0, 0, -1, lat);
        check_eq("put_keeps_rsp_data_word0", rsp_data[63:0], 64'h11);

        do_txn(1, 32'h2000_0200, rand_line(), 0, 4, 0, 0, 0, -1, lat);
        check_eq("early_ack_latency", lat, 9);
        do_txn(1, 32'h2000_0300, rand_line(), 0, 7, 0, 0, 0, -1, lat);
        check_eq("same_cycle_ack_latency", lat, 9);

        do_txn(0, 32'h3000_0000, rand_line(), 0, 0, 5, 1, 0, -1, lat);
        do_txn(0, 32'h3000_0040, rand_line(), 0, 0, 0, 3, 0, -1, lat);

        do_txn(0, 32'h4000_0000, rand_line(), 0, 0, 0, 0, 0, 3, lat);
        do_txn(0, 32'h4000_0080, rand_line(), 0, 0, 0, 0, 0, -1, lat);
        check_eq("post_abort_latency", lat, 10);

        do_txn(0, 32'h5000_0000, rand_line(), 0, 0, 0, 0, 5, -1, lat);

        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            ek = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_txn(wr, $urandom, rand_line(), 2, int'($urandom_range(1, 8)),
                   wr ? 0 : int'($urandom_range(0, 7)), ek, int'($urandom_range(0, 2)), -1, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
